// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern word out MSB-first,
// one bit per clock, with optional idle gap cycles between repetitions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a load, load_ready high
// SEND   | one pattern bit per cycle on dout, dout_valid high
// GAP    | idle spacing between repetitions, dout/dout_valid low
// DONE   | one-cycle done pulse after the final frame
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;

  logic dout_nxt, dout_valid_nxt, frame_end_nxt, done_nxt;

  // Clamp the requested length and left-align the pattern so its first bit is the MSB.
  always_comb begin
    len_eff = (load_len > WIDTH_L) ? WIDTH_L : load_len;
    shamt   = WIDTH_L - len_eff;
    aligned = load_data << shamt;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      sr      <= '0;
      hold    <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      hold    <= hold_nxt;
      len_q   <= len_nxt;
      bit_cnt <= bit_cnt_nxt;
      rep_cnt <= rep_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    hold_nxt    = hold;
    len_nxt     = len_q;
    bit_cnt_nxt = bit_cnt;
    rep_nxt     = rep_cnt;
    gap_nxt     = gap_cnt;
    case (state)
      S_IDLE: begin
        // abort wins over a simultaneous load request
        if (load_valid && !abort) begin
          hold_nxt    = aligned;
          sr_nxt      = aligned;
          len_nxt     = len_eff;
          bit_cnt_nxt = len_eff - LEN_W'(1);
          rep_nxt     = load_rep;
          state_nxt   = (len_eff == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt != '0) begin
          sr_nxt      = {sr[WIDTH-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt - LEN_W'(1);
        end else if (rep_cnt != '0) begin
          rep_nxt     = rep_cnt - REP_W'(1);
          sr_nxt      = hold;
          bit_cnt_nxt = len_q - LEN_W'(1);
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gap_nxt   = GAP_LAST;
          end else begin
            state_nxt = S_SEND;
          end
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_SEND;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    dout_valid_nxt = (state_nxt == S_SEND);
    dout_nxt       = dout_valid_nxt & sr_nxt[WIDTH-1];
    frame_end_nxt  = dout_valid_nxt && (bit_cnt_nxt == '0);
    done_nxt       = (state_nxt == S_DONE);
  end

  // Registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_end  <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      frame_end  <= frame_end_nxt;
      done       <= done_nxt;
    end
  end

  assign load_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: expected per-cycle output streams
// are built from the frame/gap/done arithmetic and compared cycle by cycle.
module tb_seq_pattern_tx;

  localparam int W   = 8;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic [3:0] load_rep = '0;
  logic       abort = 1'b0;
  logic       dout, dout_valid, frame_end, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // {load_ready, busy, dout_valid, dout, frame_end, done}
  logic [5:0] exp_q[$];
  localparam logic [5:0] IDLE_V = 6'b100000;

  seq_pattern_tx #(.WIDTH(W), .LEN_W(4), .REP_W(4), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_rep(load_rep), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .frame_end(frame_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs_vec();
    return {load_ready, busy, dout_valid, dout, frame_end, done};
  endfunction

  // Expected stream for cycles T+1 .. done cycle.
  task automatic build_expected(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    int leff;
    leff = (int'(l) > W) ? W : int'(l);
    exp_q.delete();
    if (leff > 0) begin
      for (int f = 0; f <= int'(r); f++) begin
        for (int j = 0; j < leff; j++)
          exp_q.push_back({1'b0, 1'b1, 1'b1, d[leff-1-j], (j == leff-1), 1'b0});
        if (f < int'(r))
          for (int g = 0; g < GAP; g++) exp_q.push_back(6'b010000);
      end
    end
    exp_q.push_back(6'b010001);
  endtask

  // Called at a negedge; returns at a negedge.
  // cut_kind 0 = abort after sample cut_at, 1 = reset after sample cut_at.
  task automatic play(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                      input int ign_at, input int cut_at, input int cut_kind, input string name);
    logic [5:0] o;
    build_expected(d, l, r);
    load_data  = d;
    load_len   = l;
    load_rep   = r;
    load_valid = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s load_ready before load: got %b want 1", name, load_ready);
    end
    @(posedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0 || k == ign_at + 1) load_valid = 1'b0;
      o = obs_vec();
      n_cmp++;
      if (o !== exp_q[k]) begin
        n_err++;
        $display("FAIL %s cycle T+%0d {rdy,busy,dv,dout,fe,done}: got %b want %b", name, k+1, o, exp_q[k]);
      end
      if (k == ign_at) begin
        load_data  = 8'($urandom);
        load_len   = 4'($urandom);
        load_rep   = 4'($urandom);
        load_valid = 1'b1;
      end
      if (k == cut_at) begin
        if (cut_kind == 0) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          o = obs_vec();
          n_cmp++;
          if (o !== IDLE_V) begin
            n_err++;
            $display("FAIL %s after abort: got %b want %b", name, o, IDLE_V);
          end
        end else begin
          reset = 1'b0;
          #1;
          o = obs_vec();
          n_cmp++;
          if (o !== IDLE_V) begin
            n_err++;
            $display("FAIL %s during reset: got %b want %b", name, o, IDLE_V);
          end
          @(negedge clk);
          reset = 1'b1;
        end
        return;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      o = obs_vec();
      n_cmp++;
      if (o !== IDLE_V) begin
        n_err++;
        $display("FAIL %s idle after done +%0d: got %b want %b", name, i, o, IDLE_V);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] o;
    reset = 1'b0;
    load_valid = 1'b1;
    load_len = 4'd3;
    repeat (3) @(negedge clk);
    o = obs_vec();
    n_cmp++;
    if (o !== IDLE_V) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", o, IDLE_V);
    end
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    play(8'b0000_1011, 4'd4, 4'd0, -1, -1, 0, "single_frame");
  endtask

  task automatic test_repeat_gap();
    play(8'b0000_1101, 4'd4, 4'd2, -1, -1, 0, "repeat_gap");
  endtask

  task automatic test_len_bounds();
    play(8'($urandom), 4'd0, 4'd3, -1, -1, 0, "len_zero");
    play(8'($urandom), 4'd12, 4'd0, -1, -1, 0, "len_clamp");
    play(8'($urandom), 4'd1, 4'd2, -1, -1, 0, "len_one");
  endtask

  task automatic test_abort();
    // abort sampled on the second bit of the first frame
    play(8'($urandom), 4'd5, 4'd3, -1, 1, 0, "abort");
    play(8'b1010_0110, 4'd8, 4'd1, -1, -1, 0, "load_after_abort");
  endtask

  task automatic test_reset_mid_gap();
    // len 3: samples 0..2 are bits, 3 is the first gap cycle
    play(8'b0000_0101, 4'd3, 4'd1, -1, 3, 1, "reset_gap");
    play(8'($urandom), 4'd6, 4'd1, -1, -1, 0, "load_after_reset");
  endtask

  task automatic test_ignored_load();
    play(8'b0011_0110, 4'd6, 4'd1, 4, -1, 0, "ignored_load");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [3:0] l, r;
    int ign, n;
    for (int t = 0; t < 20; t++) begin
      d = 8'($urandom);
      l = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 3));
      build_expected(d, l, r);
      n = exp_q.size();
      ign = (n >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
      play(d, l, r, ign, -1, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeat_gap();
    test_len_bounds();
    test_abort();
    test_reset_mid_gap();
    test_ignored_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the driving end of the single-bit `din` stream consumed by the FSM sequence detector. Accepts a parallel pattern word with a bit length and a repeat count over a valid/ready load handshake, then shifts it out MSB-first, one bit per clock, with a qualifying valid and a frame-end marker. Optional idle gap cycles separate repetitions. Used in place of file-driven stimulus to feed the detector in closed-loop benches and on-chip self-test.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits; must be ≥ 2 and ≤ 15.
- `LEN_W`, default 4: width of `load_len`; `WIDTH` ≤ 2^`LEN_W` − 1.
- `REP_W`, default 4: width of `load_rep`.
- `GAP`, default 2: idle cycles between repetitions; 0 is legal.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; the block is in reset while `reset`=0.
- `load_valid` input 1: a load request is present.
- `load_ready` output 1: the block can accept a load; high only in IDLE.
- `load_data` input `WIDTH`: pattern; bit `load_len`−1 is sent first.
- `load_len` input `LEN_W`: number of bits per frame.
- `load_rep` input `REP_W`: frames to send = `load_rep` + 1.
- `abort` input 1: synchronous cancel of the current transfer.
- `dout` output 1: serial bit, which connects to the detector's `din`.
- `dout_valid` output 1: `dout` carries a pattern bit this cycle.
- `frame_end` output 1: pulses with the last bit of each frame.
- `busy` output 1: high in SEND, GAP and DONE.
- `done` output 1: one-cycle pulse after the final frame completes.

## Operation
- States and their outputs:
  - **IDLE**: `load_ready`=1, and all other outputs are 0.
  - **SEND**: `dout_valid`=1, and `dout` is the current bit.
  - **GAP**: `dout`=0 and `dout_valid`=0.
  - **DONE**: `done`=1 for exactly one cycle.
- **Load handshake:** a load is accepted on a rising edge where `load_valid`=1 and `load_ready`=1. At acceptance the block captures the data, the effective length and the repeat count.
- **Effective length:** `load_len` clamped to `WIDTH`. An effective length of 0 goes IDLE→DONE, with no bits and no `frame_end`.
- **Bit order:** the shift register holds the pattern left-aligned. `dout` is the MSB of the register, and the register shifts left each SEND cycle.
- **Bit counter:** counts down from the effective length − 1. The cycle where the counter is 0 is the last bit, and `frame_end`=1 on that cycle.
- **After the last bit:**
  - If frames remain and `GAP`>0: go to GAP for exactly `GAP` cycles, then SEND.
  - If frames remain and `GAP`=0: go directly to SEND.
  - In both cases the captured pattern is reloaded from the holding register.
  - If no frames remain: go to DONE, then IDLE.
- **Repeat counter:** decrements once per completed frame. The width is `REP_W`, and no wrap occurs, because the terminal test is the counter equal to 0 at the last bit.
- **Abort:** `abort`=1 in any non-IDLE state sends the block to IDLE on the next edge. There is no `done` pulse, and `dout`/`dout_valid` go to 0 immediately after that edge. `abort` in IDLE has no effect. `abort` has priority over load acceptance in the same cycle.
- **Loads while busy:** `load_valid` while `load_ready`=0 is ignored. It is not queued.
- **Registered outputs:** `dout`, `dout_valid`, `frame_end` and `done` are registered. `load_ready` and `busy` are decoded from state.

## Timing
- **Reset values:** state IDLE, with `dout`, `dout_valid`, `frame_end`, `busy` and `done` all 0. `load_ready`=1 while in reset. Reset asserted mid-frame clears everything asynchronously, and there is no `done`.
- **First bit:** load accepted at edge T gives the first bit valid in cycle T+1.
- **Frame timing:**
  - A frame of L bits occupies cycles T+1 … T+L.
  - `frame_end` is high in cycle T+L.
- **Total transfer:** with R = `load_rep`, SEND+GAP spans (R+1)·L + R·`GAP` cycles. `done` is high in the next cycle, and `load_ready` returns the cycle after `done`.
- **Throughput:** minimum load-to-load spacing is L·(R+1) + R·`GAP` + 2 cycles.
- **Abort:** `abort` sampled at edge E gives IDLE and `load_ready`=1 in cycle E+1.

## Test plan
- **Single frame:** `load_data`=8'b0000_1011, `load_len`=4, `load_rep`=0.
  - `dout` = 1,0,1,1 in cycles T+1..T+4, with `dout_valid`=1 on all four.
  - `frame_end` at T+4, `done` at T+5, `load_ready` at T+6.
  - The detector fed from `dout` flags its sequence at the expected cycle.
- **Repeats with gap:** `GAP`=2, pattern 4'b1101, `load_rep`=2.
  - Three frames of 1,1,0,1, separated by two `dout_valid`=0 cycles.
  - Exactly three `frame_end` pulses.
  - `done` at T+17.
- **Length boundaries:**
  - `load_len`=0 → `done` at T+1, no `dout_valid`.
  - `load_len`=12 with `WIDTH`=8 → exactly 8 bits sent, starting at `load_data[7]`.
- **Abort:** `abort` during bit 2 of frame 1 of a `load_rep`=3 transfer.
  - IDLE next cycle, with `dout_valid`=0 and no `done`.
  - A new load is accepted on the following edge.
- **Reset mid-operation:** `reset`=0 during a GAP cycle.
  - All outputs 0 immediately, `load_ready`=1.
  - After release, a fresh load transmits normally.
- **Ignored load:** `load_valid` pulsed with different data while `busy`=1.
  - The stream is unchanged, and no extra frame is sent after `done`.
